ad_sample_fifo: RTL
===================

// Module: ad_sample_fifo
// PURPOSE
//  Downstream stage of the AD7606 controller.
//  - Takes the 16-bit channel words and their per-word strobe.
//  - Tags each word with its channel index and a frame-start flag.
//  - Buffers whole conversion frames in a first-word-fall-through FIFO.
//  - Hands tagged samples to the filter datapath on a valid/ready interface.
// PARAMETERS
//  DW      16  sample width (bits)
//  NUM_CH  8   channels per conversion frame (2..8)
//  DEPTH   16  FIFO entries; power of 2, >= NUM_CH
// PORTS
//  clk            in   1           system clock (50 MHz)
//  rst_n          in   1           asynchronous active-low reset
//  ad_ch          in   DW          sample word from AD controller
//  data_flag      in   1           1-cycle strobe: ad_ch valid this cycle
//  ch_first       in   1           qualifies data_flag: word is channel 0 of a frame
//  out_data       out  DW          FIFO head sample
//  out_ch         out  3           channel index of head sample
//  out_sof        out  1           head sample is channel 0
//  out_valid      out  1           FIFO not empty
//  out_ready      in   1           consumer accepts head when out_valid=1
//  fifo_level     out  clog2(DEPTH)+1   entries held
//  overflow       out  1           sticky: frame dropped for lack of space
//  frame_err      out  1           sticky: frame length violation
//  err_clr        in   1           synchronous clear of both sticky flags
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state UNSYNC, ch_cnt=0.
//  Strobe = data_flag=1. Inputs ch_first and ad_ch are ignored without it.
//  FSM:
//   UNSYNC: discard words.
//     - Strobe with ch_first -> write word as ch 0, ch_cnt=1, go to RUN.
//   RUN: each strobe writes {sof, ch_cnt, ad_ch}; ch_cnt wraps NUM_CH-1 -> 0.
//     - ch_first with ch_cnt!=0 (short frame): set frame_err, restart at
//       ch 0 with this word (written, sof=1).
//     - Strobe without ch_first at ch_cnt==0 (long frame): set frame_err,
//       discard word, go to UNSYNC.
//     - Strobe while full and no pop this cycle: discard word, set overflow,
//       go to DROP.
//   DROP: discard all words until a strobe with ch_first and at least NUM_CH
//     free entries; then write it as ch 0 and go to RUN. Partial frames
//     already stored stay in the FIFO.
//  FIFO:
//   - Write at the edge that samples the strobe. out_valid rises the next
//     cycle when the FIFO was empty (1-cycle latency).
//   - Pop on out_valid & out_ready. out_data/out_ch/out_sof are stable while
//     out_valid=1 and out_ready=0.
//   - Simultaneous push+pop is legal, including when full (level unchanged)
//     and when empty (the push only; pop is impossible).
//   - Pointers wrap mod DEPTH. fifo_level = writes - reads, 0..DEPTH.
//  Sticky flags:
//   - Set the cycle after the causing strobe; held until err_clr.
//   - Set has priority over err_clr in the same cycle.
//  Reset mid-frame: FIFO flushed, out_valid=0 next edge, state UNSYNC.
// TESTING
//  1 Before any ch_first, 5 strobes -> none stored, level=0.
//    Then 8-strobe frame (0x1000..0x1007) -> 8 outputs ch 0..7, sof only on
//    ch0, data in order.
//  2 out_ready=0, 2 frames (16 words) -> level=16.
//    17th strobe (ch_first) -> overflow=1, word dropped.
//    Drain 8 words, send frame -> accepted, level 16.
//  3 ch_first after 5 words -> frame_err=1, new word out as ch0/sof=1.
//    9th strobe without ch_first -> frame_err, UNSYNC, word absent.
//  4 Level 16, out_ready=1, strobe same cycle -> level stays 16, no overflow,
//    order preserved.
//  5 Empty FIFO, single strobe 0xABCD -> out_valid=1 next cycle with
//    out_data=0xABCD. Hold out_ready=0 for 10 cycles -> outputs unchanged.
//  6 rst_n low mid-frame with level=5 -> level=0, out_valid=0, flags 0.
//    Next non-ch_first strobes are discarded.

Source files
------------

// File: rtl/ad_sample_fifo.sv
// rtl/ad_sample_fifo.sv - AD7606 sample tagger with frame-aware first-word-fall-through FIFO
// Words are tagged {sof, ch, data}; frames are resynchronised on ch_first and dropped whole when space runs out.
module ad_sample_fifo #(
    parameter int DW     = 16,
    parameter int NUM_CH = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            ad_ch,
    input  logic                     data_flag,
    input  logic                     ch_first,
    output logic [DW-1:0]            out_data,
    output logic [2:0]               out_ch,
    output logic                     out_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] FRAME_LVL = (AW+1)'(DEPTH - NUM_CH);
    localparam logic [2:0]  LAST_CH   = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {S_UNSYNC, S_RUN, S_DROP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      ch_cnt, ch_cnt_nxt;
    logic [DW+3:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic            pop, space, room_frame;
    logic            wr_en, set_ovf, set_ferr;
    logic [2:0]      wr_ch;

    assign out_valid  = (level != '0);
    assign fifo_level = level;
    assign pop        = out_valid && out_ready;
    // A full FIFO still has room this cycle if the head is leaving.
    assign space      = (level != FULL_LVL) || pop;
    assign room_frame = (level <= FRAME_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_UNSYNC;
            ch_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            ch_cnt <= ch_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_cnt_nxt = ch_cnt;
        if (data_flag) begin
            unique case (state)
                S_UNSYNC: begin
                    if (ch_first) begin
                        if (space) begin
                            state_nxt  = S_RUN;
                            ch_cnt_nxt = 3'd1;
                        end else begin
                            state_nxt = S_DROP;
                        end
                    end
                end
                S_RUN: begin
                    if (!space)
                        state_nxt = S_DROP;
                    else if (ch_first)
                        ch_cnt_nxt = 3'd1;
                    else if (ch_cnt == 3'd0)
                        state_nxt = S_UNSYNC;
                    else
                        ch_cnt_nxt = (ch_cnt == LAST_CH) ? 3'd0 : ch_cnt + 3'd1;
                end
                S_DROP: begin
                    if (ch_first && room_frame) begin
                        state_nxt  = S_RUN;
                        ch_cnt_nxt = 3'd1;
                    end
                end
                default: state_nxt = S_UNSYNC;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_ch    = ch_cnt;
        set_ovf  = 1'b0;
        set_ferr = 1'b0;
        if (data_flag) begin
            unique case (state)
                S_UNSYNC: begin
                    if (ch_first) begin
                        wr_en   = space;
                        wr_ch   = 3'd0;
                        set_ovf = !space;
                    end
                end
                S_RUN: begin
                    if (!space) begin
                        set_ovf = 1'b1;
                    end else if (ch_first) begin
                        wr_en    = 1'b1;
                        wr_ch    = 3'd0;
                        set_ferr = (ch_cnt != 3'd0);
                    end else if (ch_cnt == 3'd0) begin
                        set_ferr = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                S_DROP: begin
                    if (ch_first && room_frame) begin
                        wr_en = 1'b1;
                        wr_ch = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {(wr_ch == 3'd0), wr_ch, ad_ch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            overflow  <= set_ovf  || (overflow  && !err_clr);
            frame_err <= set_ferr || (frame_err && !err_clr);
        end
    end

    // Head is forced to zero while empty so the outputs read 0 out of reset.
    assign {out_sof, out_ch, out_data} = out_valid ? mem[rd_ptr] : '0;

endmodule
